// File: rtl/disc_flux_capture_pkg.sv
// Shared types and constants for the flux-transition capture engine.
package disc_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_ACQUIRE,
    S_DONE
  } state_t;

  localparam int DATA_WIDTH_DEFAULT = 8;
  localparam int IDX_MARK_BIT       = DATA_WIDTH_DEFAULT - 1;

  // Word written when the timing count saturates: marker clear, count all ones.
  function automatic int unsigned overflow_word(input int unsigned data_width);
    return (32'd1 << (data_width - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/disc_flux_capture_if.sv
// Acquisition RAM write port driven by the capture engine.
interface disc_flux_capture_if #(
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 8
);
  logic                  ram_write;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_data;

  modport master (output ram_write, ram_addr, ram_data);
  modport slave  (input  ram_write, ram_addr, ram_data);
endinterface

// File: rtl/disc_flux_capture_flux_edge_detect.sv
// Rising-edge detector for the read-data channels plus the index input.
module flux_edge_detect #(
  parameter int WIDTH = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] sig,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] prev;

  // NOTE: registers are written with <= so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) prev <= '0;
    else       prev <= sig;
  end

  assign rise = sig & ~prev;

endmodule

// File: rtl/disc_flux_capture.sv
// Flux-transition timing capture: one timing word per selected-channel or index
// edge, written to the acquisition RAM, with index-gated start and stop.
module disc_flux_capture
  import disc_pkg::*;
#(
  parameter int  DATA_WIDTH = 8,
  parameter int  NCHAN      = 4,
  parameter int  ADDR_WIDTH = 19,
  parameter int  IDX_WIDTH  = 8,
  localparam int CHAN_WIDTH = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  wait_index,
  input  logic [IDX_WIDTH-1:0]  stop_count,
  input  logic [CHAN_WIDTH-1:0] chan_sel,
  input  logic [NCHAN-1:0]      rd_data,
  input  logic                  index,
  disc_flux_capture_if.master   ram,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_full
);

  localparam int                   CW       = DATA_WIDTH - 1;
  localparam logic [CW-1:0]        CNT_MAX  = CW'(overflow_word(DATA_WIDTH));
  localparam logic [DATA_WIDTH-1:0] OVF_WORD = DATA_WIDTH'(overflow_word(DATA_WIDTH));

  state_t                state;
  logic [CW-1:0]         count;
  logic [IDX_WIDTH-1:0]  idx_cnt;
  logic [IDX_WIDTH-1:0]  idx_next;
  logic [CHAN_WIDTH-1:0] chan_q;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [NCHAN:0]        rise;
  logic [NCHAN-1:0]      flux_rise;
  logic                  flux_edge;
  logic                  index_edge;

  flux_edge_detect #(.WIDTH(NCHAN + 1)) u_edge (
    .clock (clock),
    .reset (reset),
    .sig   ({index, rd_data}),
    .rise  (rise)
  );

  assign flux_rise  = rise[NCHAN-1:0];
  assign flux_edge  = flux_rise[chan_q];
  assign index_edge = rise[NCHAN];
  assign idx_next   = idx_cnt + 1'b1;
  assign busy       = (state == S_ARMED) || (state == S_ACQUIRE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      count        <= CW'(1);
      idx_cnt      <= '0;
      chan_q       <= '0;
      wr_ptr       <= '0;
      ram.ram_write <= 1'b0;
      ram.ram_addr <= '0;
      ram.ram_data <= '0;
      done         <= 1'b0;
      ram_full     <= 1'b0;
    end else begin
      ram.ram_write <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start && !abort) begin
            chan_q       <= chan_sel;
            wr_ptr       <= '0;
            ram.ram_addr <= '0;
            idx_cnt      <= '0;
            count        <= CW'(1);
            done         <= 1'b0;
            ram_full     <= 1'b0;
            state        <= wait_index ? S_ARMED : S_ACQUIRE;
          end
        end

        S_ARMED: begin
          if (abort) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end else if (index_edge) begin
            count   <= CW'(1);
            idx_cnt <= IDX_WIDTH'(1);
            state   <= S_ACQUIRE;
          end
        end

        S_ACQUIRE: begin
          if (abort) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end else if (flux_edge || index_edge || count == CNT_MAX) begin
            // A coincident flux+index edge yields one word with the marker set.
            ram.ram_write <= 1'b1;
            ram.ram_addr  <= wr_ptr;
            ram.ram_data  <= (flux_edge || index_edge) ? {index_edge, count} : OVF_WORD;
            wr_ptr        <= wr_ptr + 1'b1;
            count         <= CW'(1);
            if (index_edge) idx_cnt <= idx_next;
            if (wr_ptr == '1) begin
              ram_full <= 1'b1;
              state    <= S_DONE;
            end else if (index_edge && stop_count != '0 && idx_next == stop_count) begin
              state <= S_DONE;
            end
          end else begin
            count <= count + 1'b1;
          end
        end

        S_DONE: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
